// File: rtl/topic_consolidator.sv
// Topic consolidator: collects per-theta episode phases into a ping-pong slot bank and
// reduces the closed bank into a topic signature on each delta tick. Optional feature: TOPIC_HIST_EN.
module topic_consolidator #(
    parameter int              NSLOT    = 5,
    parameter int              DW       = 8,
    parameter logic [DW-1:0]   COH_TH   = 8'd32,
    parameter logic [DW-1:0]   SHIFT_TH = 8'd64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              episode_valid,
    input  logic [DW-1:0]     episode_phase,
    input  logic [2:0]        theta_cnt,
    input  logic              delta_tick,
    output logic              topic_valid,
    input  logic              topic_ready,
    output logic [DW+2:0]     topic_sum,
    output logic [2:0]        topic_count,
    output logic [DW-1:0]     topic_min,
    output logic [DW-1:0]     topic_max,
    output logic [DW-1:0]     topic_span,
    output logic              topic_coherent,
    output logic              topic_shift,
    output logic              busy,
    output logic              topic_overrun
);

    localparam int         SW   = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [2:0] LAST = 3'(NSLOT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REDUCE  = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_bank;
    logic [2:0]           r_ptr;
    logic [DW-1:0]        r_phase [2][NSLOT];
    logic [NSLOT-1:0]     r_vld   [2];

    logic [DW+2:0]        r_acc_sum;
    logic [2:0]           r_acc_cnt;
    logic [DW-1:0]        r_acc_min;
    logic [DW-1:0]        r_acc_max;

    logic                 r_topic_valid;
    logic [DW+2:0]        r_topic_sum;
    logic [2:0]           r_topic_count;
    logic [DW-1:0]        r_topic_min;
    logic [DW-1:0]        r_topic_max;
    logic [DW-1:0]        r_topic_span;
    logic                 r_topic_coherent;
    logic                 r_busy;
    logic                 r_topic_overrun;

    logic                 w_wr_en;
    logic [SW-1:0]        w_wslot;
    logic [SW-1:0]        w_rslot;
    logic                 w_rd_bank;
    logic                 w_rd_vld;
    logic [DW-1:0]        w_rd_phase;
    logic                 w_load;
    logic                 w_empty;
    logic [DW-1:0]        w_pub_min;
    logic [DW-1:0]        w_pub_max;
    logic [DW-1:0]        w_span;
    logic                 w_coh;

    // Write-port decode and closed-bank read port.
    always_comb begin
        w_wr_en    = episode_valid && (theta_cnt < 3'(NSLOT));
        w_wslot    = theta_cnt[SW-1:0];
        w_rslot    = r_ptr[SW-1:0];
        w_rd_bank  = ~r_bank;
        w_rd_vld   = r_vld[w_rd_bank][w_rslot];
        w_rd_phase = r_phase[w_rd_bank][w_rslot];
    end

    // Signature finalisation seen in PUBLISH; an empty topic publishes zeros and is never coherent.
    always_comb begin
        w_load    = (!r_topic_valid) || topic_ready;
        w_empty   = (r_acc_cnt == 3'd0);
        w_pub_min = {DW{1'b0}};
        w_pub_max = {DW{1'b0}};
        if (w_empty) begin
            w_pub_min = {DW{1'b0}};
            w_pub_max = {DW{1'b0}};
        end else begin
            w_pub_min = r_acc_min;
            w_pub_max = r_acc_max;
        end
        w_span = w_pub_max - w_pub_min;
        if (w_empty) begin
            w_coh = 1'b0;
        end else begin
            w_coh = (w_span <= COH_TH);
        end
    end

`ifdef TOPIC_HIST_EN
    logic [DW-1:0] r_prev_mid;
    logic          r_prev_ok;
    logic          r_topic_shift;
    logic [DW:0]   w_mid_sum;
    logic [DW-1:0] w_mid;
    logic [DW-1:0] w_mid_diff;
    logic          w_shift;

    // Midpoint of this topic and its distance from the previous published midpoint.
    always_comb begin
        w_mid_sum = {1'b0, r_acc_min} + {1'b0, r_acc_max};
        w_mid     = w_mid_sum[DW:1];
        if (w_mid >= r_prev_mid) begin
            w_mid_diff = w_mid - r_prev_mid;
        end else begin
            w_mid_diff = r_prev_mid - w_mid;
        end
        w_shift = r_prev_ok && (w_mid_diff > SHIFT_TH);
    end

    assign topic_shift = r_topic_shift;
`else
    logic w_unused_shift_th;
    assign w_unused_shift_th = ^SHIFT_TH;
    assign topic_shift       = 1'b0;
`endif

    // Slot bank: writes land in the active bank, REDUCE retires slots of the closed bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                r_vld[b] <= {NSLOT{1'b0}};
                for (int s = 0; s < NSLOT; s++) begin
                    r_phase[b][s] <= {DW{1'b0}};
                end
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < NSLOT; s++) begin
                    if (w_wr_en && (r_bank == 1'(b)) && (w_wslot == SW'(s))) begin
                        r_vld[b][s]   <= 1'b1;
                        r_phase[b][s] <= episode_phase;
                    end else if ((r_state == ST_REDUCE) && (r_bank != 1'(b)) && (w_rslot == SW'(s))) begin
                        r_vld[b][s] <= 1'b0;
                    end
                end
            end
        end
    end

    // Reducer FSM with registered signature, handshake and overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_bank           <= 1'b0;
            r_ptr            <= 3'd0;
            r_acc_sum        <= {(DW+3){1'b0}};
            r_acc_cnt        <= 3'd0;
            r_acc_min        <= {DW{1'b0}};
            r_acc_max        <= {DW{1'b0}};
            r_topic_valid    <= 1'b0;
            r_topic_sum      <= {(DW+3){1'b0}};
            r_topic_count    <= 3'd0;
            r_topic_min      <= {DW{1'b0}};
            r_topic_max      <= {DW{1'b0}};
            r_topic_span     <= {DW{1'b0}};
            r_topic_coherent <= 1'b0;
            r_busy           <= 1'b0;
            r_topic_overrun  <= 1'b0;
`ifdef TOPIC_HIST_EN
            r_prev_mid       <= {DW{1'b0}};
            r_prev_ok        <= 1'b0;
            r_topic_shift    <= 1'b0;
`endif
        end else begin
            if (r_topic_valid && topic_ready) begin
                r_topic_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (delta_tick) begin
                        r_bank    <= ~r_bank;
                        r_acc_sum <= {(DW+3){1'b0}};
                        r_acc_cnt <= 3'd0;
                        r_acc_min <= {DW{1'b1}};
                        r_acc_max <= {DW{1'b0}};
                        r_ptr     <= 3'd0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_REDUCE;
                    end else begin
                        r_busy    <= 1'b0;
                    end
                end
                ST_REDUCE: begin
                    if (delta_tick) begin
                        r_topic_overrun <= 1'b1;
                    end
                    if (w_rd_vld) begin
                        r_acc_sum <= r_acc_sum + {3'b000, w_rd_phase};
                        r_acc_cnt <= r_acc_cnt + 3'd1;
                        if (w_rd_phase < r_acc_min) begin
                            r_acc_min <= w_rd_phase;
                        end
                        if (w_rd_phase > r_acc_max) begin
                            r_acc_max <= w_rd_phase;
                        end
                    end
                    if (r_ptr == LAST) begin
                        r_state <= ST_PUBLISH;
                    end else begin
                        r_ptr   <= r_ptr + 3'd1;
                    end
                end
                ST_PUBLISH: begin
                    if (delta_tick) begin
                        r_topic_overrun <= 1'b1;
                    end
                    if (w_load) begin
                        r_topic_valid    <= 1'b1;
                        r_topic_sum      <= r_acc_sum;
                        r_topic_count    <= r_acc_cnt;
                        r_topic_min      <= w_pub_min;
                        r_topic_max      <= w_pub_max;
                        r_topic_span     <= w_span;
                        r_topic_coherent <= w_coh;
`ifdef TOPIC_HIST_EN
                        if (!w_empty) begin
                            r_topic_shift <= w_shift;
                            r_prev_mid    <= w_mid;
                            r_prev_ok     <= 1'b1;
                        end else begin
                            r_topic_shift <= 1'b0;
                        end
`endif
                    end else begin
                        r_topic_overrun <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign topic_valid    = r_topic_valid;
    assign topic_sum      = r_topic_sum;
    assign topic_count    = r_topic_count;
    assign topic_min      = r_topic_min;
    assign topic_max      = r_topic_max;
    assign topic_span     = r_topic_span;
    assign topic_coherent = r_topic_coherent;
    assign busy           = r_busy;
    assign topic_overrun  = r_topic_overrun;

endmodule

// File: doc/topic_consolidator.md
Name: topic_consolidator

Overview:
- Downstream consumer of the delta (topic-boundary) stage.
- Collects one phase summary per theta episode into a ping-pong slot bank indexed by the delta stage's theta position.
- On each topic boundary, reduces the closed bank sequentially into a topic signature: sum, count, min, max, span and a coherence flag.
- Presents the signature on a valid/ready port to the topic-level context logic.

Parameters:
- NSLOT, 5: theta slots per topic; legal range 1..7; matches the delta stage's theta-per-delta count.
- DW, 8: episode phase width in bits.
- COH_TH, 8'd32: maximum span (max-min) for the topic to be flagged coherent; DW bits wide.
- SHIFT_TH, 8'd64: midpoint shift threshold; used only with TOPIC_HIST_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- episode_valid  in  1  one-cycle pulse; episode summary present
- episode_phase  in  DW  episode phase summary
- theta_cnt  in  3  slot index for the episode (delta stage position)
- delta_tick  in  1  one-cycle topic boundary pulse
- topic_valid  out  1  signature available
- topic_ready  in  1  consumer accepts
- topic_sum  out  DW+3  sum of valid slot phases
- topic_count  out  3  number of valid slots
- topic_min  out  DW  minimum valid phase
- topic_max  out  DW  maximum valid phase
- topic_span  out  DW  topic_max - topic_min
- topic_coherent  out  1  count!=0 and span<=COH_TH
- topic_shift  out  1  midpoint shift flag; 0 without TOPIC_HIST_EN
- busy  out  1  reducer not IDLE
- topic_overrun  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0.
  - Both banks' slot-valid bits cleared; active bank = 0; FSM IDLE.
- Write path, active in every FSM state:
  - episode_valid with theta_cnt<NSLOT writes episode_phase into the active bank slot and sets that slot's valid bit.
  - Rewriting a slot in the same topic: last write wins; counted once.
  - theta_cnt>=NSLOT: write ignored, no flag.
- FSM states IDLE, REDUCE, PUBLISH:
  - IDLE + delta_tick, at edge E0:
    - Swap active bank. An episode_valid in the same cycle is written to the closing bank, i.e. the old topic.
    - Initialise accumulators: sum=0, cnt=0, min=all-ones, max=0, slot ptr=0.
    - Go to REDUCE.
  - REDUCE, edges E1..E_NSLOT: one slot per edge, slot ptr 0..NSLOT-1.
    - If the slot is valid: accumulate sum, cnt+1, update min/max.
    - Clear that slot's valid bit.
    - After slot NSLOT-1, go to PUBLISH.
  - PUBLISH, edge E_NSLOT+1: compute span and coherent.
    - Empty topic (cnt=0): min=max=span=0, coherent=0. An output is still produced.
    - If the output register is free, or topic_valid&&topic_ready this cycle: load outputs and set topic_valid=1.
    - Otherwise: drop the result and set topic_overrun.
    - Go to IDLE.
  - Latency: topic_valid rises NSLOT+1 edges after the edge that sampled delta_tick (6 for NSLOT=5).
- delta_tick while busy (REDUCE or PUBLISH):
  - Ignored: no swap.
  - Sets topic_overrun.
  - Episodes continue into the current active bank and are merged into the next topic.
- Output handshake:
  - Output fields are held stable while topic_valid=1 and topic_ready=0.
  - topic_valid clears on the edge where topic_valid&&topic_ready, unless PUBLISH reloads it on that same edge.
- topic_overrun: sticky; cleared only by reset.
- Width rules: sum is DW+3 bits and cannot overflow for NSLOT<=7. All compares unsigned; phases are not treated as circular.

Optional Feature:
- Macro TOPIC_HIST_EN.
- Defined:
  - Module keeps prev_mid (DW bits) and a prev_ok bit, both reset to 0.
  - At a loading PUBLISH with cnt!=0: mid=(min+max)>>1, computed with a DW+1-bit add.
  - topic_shift = prev_ok && |mid-prev_mid| > SHIFT_TH.
  - Then prev_mid<=mid and prev_ok<=1.
  - Empty topics and dropped results leave the history untouched; topic_shift=0 for them.
- Undefined: no history registers; topic_shift tied 0.

Test Plan:
- Single topic: episodes at slots 0..4 with phases 10,20,30,40,50, then delta_tick -> topic_valid 6 cycles later; sum=150, count=5, min=10, max=50, span=40, coherent=0.
- Rewrite and bad slot: slot 2 written 100 then 104, write to slot 6, delta_tick -> count=1, sum=104, span=0, coherent=1; slot 6 write ignored.
- Same-cycle event: episode_valid(slot 4, phase 7) in the same cycle as delta_tick -> counted in the closing topic; next topic starts empty; a second delta_tick gives count=0, coherent=0.
- Back-pressure: topic_ready=0 through two topics -> first signature held stable, second dropped, topic_overrun=1; raise ready -> first accepted, topic_valid=0.
- Busy tick: second delta_tick 2 cycles after the first -> topic_overrun=1, no bank swap; episodes written meanwhile appear in the following topic.
- TOPIC_HIST_EN: topic A min/max 10/30 (mid 20), topic B min/max 150/170 (mid 160) -> A shift=0, B shift=1; topic C mid 170 -> shift=0.
